uart_cmd_ctrl: RTL and testbench



---
 rtl/uart_cmd_ctrl_if.sv | 53 +++++
 rtl/uart_cmd_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 356 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_ctrl_if.sv
// Bus bundle between the UART command controller and its environment
// (UART RX/TX front end and register file).
interface uart_cmd_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
);

  localparam int unsigned ERR_WIDTH = 8;

  // UART receive side
  logic [DATA_WIDTH-1:0] rx_p_data;
  logic                  rx_data_valid;
  logic                  par_err;
  logic                  stp_err;

  // UART transmit side
  logic [DATA_WIDTH-1:0] tx_p_data;
  logic                  tx_data_valid;
  logic                  tx_busy;

  // Register-file port
  logic [ADDR_WIDTH-1:0] rf_addr;
  logic                  rf_wr_en;
  logic [DATA_WIDTH-1:0] rf_wr_data;
  logic                  rf_rd_en;
  logic [DATA_WIDTH-1:0] rf_rd_data;
  logic                  rf_rd_valid;

  // Status
  logic [ERR_WIDTH-1:0]  err_cnt;
  logic                  cmd_busy;

  // Controller side
  modport master (
    input  rx_p_data, rx_data_valid, par_err, stp_err,
    output tx_p_data, tx_data_valid,
    input  tx_busy,
    output rf_addr, rf_wr_en, rf_wr_data, rf_rd_en,
    input  rf_rd_data, rf_rd_valid,
    output err_cnt, cmd_busy
  );

  // Environment side (UART front end, register file)
  modport slave (
    output rx_p_data, rx_data_valid, par_err, stp_err,
    input  tx_p_data, tx_data_valid,
    output tx_busy,
    input  rf_addr, rf_wr_en, rf_wr_data, rf_rd_en,
    output rf_rd_data, rf_rd_valid,
    input  err_cnt, cmd_busy
  );

endinterface

// File: rtl/uart_cmd_ctrl.sv
// UART command controller: decodes byte-framed write/read/unknown commands,
// drives the register-file port and returns one response byte per command.
module uart_cmd_ctrl #(
  parameter int unsigned           DATA_WIDTH = 8,
  parameter int unsigned           ADDR_WIDTH = 4,
  parameter logic [DATA_WIDTH-1:0] WR_CMD     = DATA_WIDTH'(8'hAA),
  parameter logic [DATA_WIDTH-1:0] RD_CMD     = DATA_WIDTH'(8'hBB),
  parameter logic [DATA_WIDTH-1:0] ACK_BYTE   = DATA_WIDTH'(8'h55),
  parameter logic [DATA_WIDTH-1:0] NACK_BYTE  = DATA_WIDTH'(8'hEE)
) (
  input  logic           clk,
  input  logic           rst,
  uart_cmd_ctrl_if.master bus
);

  localparam int unsigned ERR_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_DATA = 3'd2,
    RD_ADDR = 3'd3,
    RD_WAIT = 3'd4,
    TX_REQ  = 3'd5,
    TX_WAIT = 3'd6
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  wr_en_q, wr_en_d;
  logic                  rd_en_q, rd_en_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  tx_valid_q, tx_valid_d;
  logic                  seen_busy_q, seen_busy_d;
  logic [ERR_WIDTH-1:0]  err_q, err_d;
  logic                  busy_q, busy_d;

  logic                  rx_good;
  logic                  rx_bad;

  // Classify the incoming frame
  always_comb begin
    rx_good = bus.rx_data_valid & ~bus.par_err & ~bus.stp_err;
    rx_bad  = bus.rx_data_valid & (bus.par_err | bus.stp_err);
  end

  // Next-state and next-output decode
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wr_data_d   = wr_data_q;
    wr_en_d     = 1'b0;
    rd_en_d     = 1'b0;
    tx_data_d   = tx_data_q;
    tx_valid_d  = 1'b0;
    seen_busy_d = seen_busy_q;
    err_d       = err_q;
    busy_d      = 1'b0;

    // Bad frames are counted in every state; the counter sticks at all-ones
    if (rx_bad && (err_q != {ERR_WIDTH{1'b1}})) begin
      err_d = err_q + ERR_WIDTH'(1);
    end

    case (state_q)
      IDLE: begin
        if (rx_good) begin
          if (bus.rx_p_data == WR_CMD) begin
            state_d = WR_ADDR;
          end else if (bus.rx_p_data == RD_CMD) begin
            state_d = RD_ADDR;
          end else begin
            tx_data_d = NACK_BYTE;
            state_d   = TX_REQ;
          end
        end
      end

      WR_ADDR: begin
        if (rx_bad) begin
          state_d = IDLE;
        end else if (rx_good) begin
          addr_d  = bus.rx_p_data[ADDR_WIDTH-1:0];
          state_d = WR_DATA;
        end
      end

      WR_DATA: begin
        if (rx_bad) begin
          state_d = IDLE;
        end else if (rx_good) begin
          wr_data_d = bus.rx_p_data;
          wr_en_d   = 1'b1;
          tx_data_d = ACK_BYTE;
          state_d   = TX_REQ;
        end
      end

      RD_ADDR: begin
        if (rx_bad) begin
          state_d = IDLE;
        end else if (rx_good) begin
          addr_d  = bus.rx_p_data[ADDR_WIDTH-1:0];
          rd_en_d = 1'b1;
          state_d = RD_WAIT;
        end
      end

      RD_WAIT: begin
        if (bus.rf_rd_valid) begin
          tx_data_d = bus.rf_rd_data;
          state_d   = TX_REQ;
        end
      end

      TX_REQ: begin
        if (!bus.tx_busy) begin
          tx_valid_d  = 1'b1;
          seen_busy_d = 1'b0;
          state_d     = TX_WAIT;
        end
      end

      TX_WAIT: begin
        // Transmitter must first accept (busy high) and then finish (busy low)
        if (!seen_busy_q) begin
          if (bus.tx_busy) begin
            seen_busy_d = 1'b1;
          end
        end else if (!bus.tx_busy) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wr_data_q   <= '0;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      seen_busy_q <= 1'b0;
      err_q       <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wr_data_q   <= wr_data_d;
      wr_en_q     <= wr_en_d;
      rd_en_q     <= rd_en_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      seen_busy_q <= seen_busy_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.rf_addr       = addr_q;
  assign bus.rf_wr_data    = wr_data_q;
  assign bus.rf_wr_en      = wr_en_q;
  assign bus.rf_rd_en      = rd_en_q;
  assign bus.tx_p_data     = tx_data_q;
  assign bus.tx_data_valid = tx_valid_q;
  assign bus.err_cnt       = err_q;
  assign bus.cmd_busy      = busy_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl: directed scenarios plus randomized
// command traffic checked against a transaction-level reference model.
module tb_uart_cmd_ctrl;

  logic clk;
  logic rst;

  uart_cmd_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

  uart_cmd_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Transmitter busy: either scripted by the main sequence or automatic
  logic tx_auto;
  logic tx_busy_man;
  logic tx_busy_auto;
  logic rd_auto;
  assign bus.tx_busy = tx_auto ? tx_busy_auto : tx_busy_man;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state and expected / observed event logs
  logic [7:0]  ref_mem [16];
  logic [7:0]  rf_mem  [16];
  int          exp_err;
  logic [7:0]  exp_tx[$];
  logic [7:0]  obs_tx[$];
  logic [11:0] exp_wr[$];
  logic [11:0] obs_wr[$];
  logic [3:0]  exp_rd[$];
  logic [3:0]  obs_rd[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_assert++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic pe, input logic se);
    bus.rx_p_data     = b;
    bus.par_err       = pe;
    bus.stp_err       = se;
    bus.rx_data_valid = 1'b1;
    tick();
    bus.rx_data_valid = 1'b0;
    bus.par_err       = 1'b0;
    bus.stp_err       = 1'b0;
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 2)) tick();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.cmd_busy && n < 400) begin
      tick();
      n++;
    end
    check("idle_timeout", 32'(bus.cmd_busy), 32'd0);
  endtask

  function automatic void model_bad();
    if (exp_err < 255) exp_err++;
  endfunction

  function automatic void model_write(input logic [3:0] a, input logic [7:0] d);
    ref_mem[a] = d;
    exp_wr.push_back({a, d});
    exp_tx.push_back(8'h55);
  endfunction

  function automatic void model_read(input logic [3:0] a);
    exp_rd.push_back(a);
    exp_tx.push_back(ref_mem[a]);
  endfunction

  // Let the command finish, then compare the observed event logs to the model
  task automatic settle(input string tag);
    wait_idle();
    repeat (3) tick();
    check({tag, "_err"}, 32'(bus.err_cnt), 32'(exp_err));
    check({tag, "_ntx"}, 32'(obs_tx.size()), 32'(exp_tx.size()));
    while (obs_tx.size() > 0 && exp_tx.size() > 0)
      check({tag, "_tx"}, 32'(obs_tx.pop_front()), 32'(exp_tx.pop_front()));
    check({tag, "_nwr"}, 32'(obs_wr.size()), 32'(exp_wr.size()));
    while (obs_wr.size() > 0 && exp_wr.size() > 0)
      check({tag, "_wr"}, 32'(obs_wr.pop_front()), 32'(exp_wr.pop_front()));
    check({tag, "_nrd"}, 32'(obs_rd.size()), 32'(exp_rd.size()));
    while (obs_rd.size() > 0 && exp_rd.size() > 0)
      check({tag, "_rd"}, 32'(obs_rd.pop_front()), 32'(exp_rd.pop_front()));
    obs_tx.delete(); exp_tx.delete();
    obs_wr.delete(); exp_wr.delete();
    obs_rd.delete(); exp_rd.delete();
  endtask

  // Environment: register-file stub, transmitter model and event monitor
  initial begin : env
    int rd_pend;
    logic [3:0] rd_addr_l;
    int tx_gap;
    int tx_hold;
    rd_pend = 0;
    rd_addr_l = '0;
    tx_gap = 0;
    tx_hold = 0;
    tx_busy_auto = 1'b0;
    bus.rf_rd_valid = 1'b0;
    bus.rf_rd_data  = '0;
    for (int i = 0; i < 16; i++) rf_mem[i] = 8'(8'hA0 + i);
    forever begin
      @(posedge clk);
      #1;
      if (rd_pend != 0) begin
        bus.rf_rd_valid = 1'b1;
        bus.rf_rd_data  = rf_mem[rd_addr_l];
        rd_pend = 0;
      end else begin
        bus.rf_rd_valid = 1'b0;
      end
      if (bus.rf_rd_en) begin
        obs_rd.push_back(bus.rf_addr);
        if (rd_auto) begin
          rd_pend   = 1;
          rd_addr_l = bus.rf_addr;
        end
      end
      if (bus.rf_wr_en) begin
        rf_mem[bus.rf_addr] = bus.rf_wr_data;
        obs_wr.push_back({bus.rf_addr, bus.rf_wr_data});
      end
      if (bus.tx_data_valid) obs_tx.push_back(bus.tx_p_data);
      if (tx_auto) begin
        if (bus.tx_data_valid) begin
          tx_gap  = $urandom_range(0, 2);
          tx_hold = $urandom_range(1, 4);
        end else if (tx_gap > 0) begin
          tx_gap--;
        end else if (tx_hold > 0) begin
          tx_busy_auto = 1'b1;
          tx_hold--;
        end else begin
          tx_busy_auto = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: observed timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [7:0] op;
    logic [7:0] d;
    logic [3:0] a;
    logic [1:0] code;
    logic       saw_valid;
    int         kind;

    rst = 1'b1;
    tx_auto = 1'b1;
    tx_busy_man = 1'b0;
    rd_auto = 1'b1;
    bus.rx_p_data = '0;
    bus.rx_data_valid = 1'b0;
    bus.par_err = 1'b0;
    bus.stp_err = 1'b0;
    exp_err = 0;
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'(8'hA0 + i);

    // Reset state
    repeat (2) tick();
    check("rst_tx_data", 32'(bus.tx_p_data), 32'h0);
    check("rst_tx_valid", 32'(bus.tx_data_valid), 32'h0);
    check("rst_rf_addr", 32'(bus.rf_addr), 32'h0);
    check("rst_rf_wr_data", 32'(bus.rf_wr_data), 32'h0);
    check("rst_strobes", 32'({bus.rf_wr_en, bus.rf_rd_en}), 32'h0);
    check("rst_err_cnt", 32'(bus.err_cnt), 32'h0);
    check("rst_cmd_busy", 32'(bus.cmd_busy), 32'h0);
    rst = 1'b0;
    tick();

    // Write AA,03,5C
    send(8'hAA, 0, 0);
    send(8'h03, 0, 0);
    send(8'h5C, 0, 0);
    check("wr_en_pulse", 32'(bus.rf_wr_en), 32'h1);
    check("wr_addr", 32'(bus.rf_addr), 32'h3);
    check("wr_data", 32'(bus.rf_wr_data), 32'h5C);
    tick();
    check("wr_en_single", 32'(bus.rf_wr_en), 32'h0);
    model_write(4'h3, 8'h5C);
    settle("write");
    check("wr_data_hold", 32'(bus.rf_wr_data), 32'h5C);

    // Read BB,07 (stub holds A7 at address 7)
    send(8'hBB, 0, 0);
    gap();
    send(8'h07, 0, 0);
    check("rd_en_pulse", 32'(bus.rf_rd_en), 32'h1);
    check("rd_addr", 32'(bus.rf_addr), 32'h7);
    tick();
    check("rd_en_single", 32'(bus.rf_rd_en), 32'h0);
    model_read(4'h7);
    check("rd_model_a7", 32'(exp_tx[0]), 32'hA7);
    settle("read");

    // Unknown opcode
    send(8'h12, 0, 0);
    check("nack_busy", 32'(bus.cmd_busy), 32'h1);
    exp_tx.push_back(8'hEE);
    settle("nack");

    // Abort on parity error, then a normal read of the same address
    send(8'hAA, 0, 0);
    send(8'h03, 0, 0);
    send(8'h5C, 1, 0);
    model_bad();
    check("abort_err_cnt", 32'(bus.err_cnt), 32'h1);
    check("abort_idle", 32'(bus.cmd_busy), 32'h0);
    check("abort_no_wr", 32'(bus.rf_wr_en), 32'h0);
    settle("abort");
    send(8'hBB, 0, 0);
    send(8'h03, 0, 0);
    model_read(4'h3);
    settle("after_abort");

    // Backpressure: transmitter busy for 20 cycles on entry to TX_REQ
    tx_auto = 1'b0;
    tx_busy_man = 1'b1;
    send(8'h12, 0, 0);
    exp_tx.push_back(8'hEE);
    saw_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i % 4 == 1) send(8'hAA, 0, 0);
      else tick();
      saw_valid = saw_valid | bus.tx_data_valid;
    end
    check("bp_hold_low", 32'(saw_valid), 32'h0);
    tx_busy_man = 1'b0;
    tick();
    check("bp_release_valid", 32'(bus.tx_data_valid), 32'h1);
    check("bp_release_data", 32'(bus.tx_p_data), 32'hEE);
    tick();
    check("bp_valid_single", 32'(bus.tx_data_valid), 32'h0);
    tx_busy_man = 1'b1;
    repeat (3) tick();
    check("bp_data_stable", 32'(bus.tx_p_data), 32'hEE);
    tx_busy_man = 1'b0;
    settle("backpressure");
    tx_auto = 1'b1;

    // Randomized command traffic
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 5);
      a = 4'($urandom);
      d = 8'($urandom);
      code = 2'($urandom_range(1, 3));
      case (kind)
        0, 1: begin
          send(8'hAA, 0, 0); gap();
          send({4'($urandom), a}, 0, 0); gap();
          send(d, 0, 0);
          model_write(a, d);
        end
        2, 3: begin
          send(8'hBB, 0, 0); gap();
          send({4'($urandom), a}, 0, 0);
          model_read(a);
        end
        4: begin
          op = 8'($urandom);
          while (op == 8'hAA || op == 8'hBB) op = 8'($urandom);
          send(op, 0, 0);
          exp_tx.push_back(8'hEE);
        end
        default: begin
          case ($urandom_range(0, 3))
            0: begin send(8'hAA, 0, 0); gap(); end
            1: begin send(8'hAA, 0, 0); gap(); send({4'h0, a}, 0, 0); gap(); end
            2: begin send(8'hBB, 0, 0); gap(); end
            default: ;
          endcase
          send(d, code[0], code[1]);
          model_bad();
        end
      endcase
      settle("random");
    end

    // Error counter saturation
    for (int i = 0; i < 300; i++) begin
      send(8'($urandom), 0, 1);
      model_bad();
      tick();
    end
    check("sat_err_cnt", 32'(bus.err_cnt), 32'hFF);
    check("sat_model", 32'(exp_err), 32'd255);
    settle("saturate");

    // Reset while waiting for read data
    rd_auto = 1'b0;
    send(8'hBB, 0, 0);
    send(8'h05, 0, 0);
    exp_rd.push_back(4'h5);
    repeat (3) tick();
    check("rdwait_busy", 32'(bus.cmd_busy), 32'h1);
    #3;
    rst = 1'b1;
    #1;
    exp_err = 0;
    check("mid_rst_tx", 32'({bus.tx_p_data, bus.tx_data_valid}), 32'h0);
    check("mid_rst_rf", 32'({bus.rf_addr, bus.rf_wr_data, bus.rf_wr_en, bus.rf_rd_en}), 32'h0);
    check("mid_rst_err_cnt", 32'(bus.err_cnt), 32'h0);
    check("mid_rst_busy", 32'(bus.cmd_busy), 32'h0);
    tick();
    rst = 1'b0;
    rd_auto = 1'b1;
    settle("mid_reset");

    // Recovery after reset
    send(8'hAA, 0, 0);
    send(8'h0A, 0, 0);
    send(8'h3C, 0, 0);
    model_write(4'hA, 8'h3C);
    settle("recover_wr");
    send(8'hBB, 0, 0);
    send(8'h0A, 0, 0);
    model_read(4'hA);
    settle("recover_rd");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
